// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite constants and the per-port arbitration state type.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // IDLE: nothing outstanding; WAIT: address phase held locally; DATA: in downstream data phase
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DATA = 2'd2
    } port_state_e;

endpackage

// File: rtl/ahb_lite_arbiter_nx1_if.sv
// Bus bundle for the N-master to 1-slave AHB-Lite arbiter.
// s_* signals face the upstream masters, m_* signals face the shared downstream path.
interface ahb_lite_arbiter_nx1_if #(
    parameter int unsigned HDATA_WIDTH = 64,
    parameter int unsigned HADDR_WIDTH = 17,
    parameter int unsigned HPORT_COUNT = 2
);

    logic [HPORT_COUNT-1:0][HADDR_WIDTH-1:0] s_HADDR;
    logic [HPORT_COUNT-1:0][1:0]             s_HTRANS;
    logic [HPORT_COUNT-1:0][2:0]             s_HSIZE;
    logic [HPORT_COUNT-1:0]                  s_HWRITE;
    logic [HPORT_COUNT-1:0][HDATA_WIDTH-1:0] s_HWDATA;
    logic [HPORT_COUNT-1:0][HDATA_WIDTH-1:0] s_HRDATA;
    logic [HPORT_COUNT-1:0]                  s_HREADY;
    logic [HPORT_COUNT-1:0]                  s_HRESP;

    logic [HADDR_WIDTH-1:0] m_HADDR;
    logic [1:0]             m_HTRANS;
    logic [2:0]             m_HSIZE;
    logic                   m_HWRITE;
    logic [HDATA_WIDTH-1:0] m_HWDATA;
    logic [HDATA_WIDTH-1:0] m_HRDATA;
    logic                   m_HREADY;
    logic                   m_HRESP;

    // Environment view: upstream masters plus the downstream slave.
    modport master (
        output s_HADDR, s_HTRANS, s_HSIZE, s_HWRITE, s_HWDATA,
        output m_HRDATA, m_HREADY, m_HRESP,
        input  s_HRDATA, s_HREADY, s_HRESP,
        input  m_HADDR, m_HTRANS, m_HSIZE, m_HWRITE, m_HWDATA
    );

    // Arbiter view.
    modport slave (
        input  s_HADDR, s_HTRANS, s_HSIZE, s_HWRITE, s_HWDATA,
        input  m_HRDATA, m_HREADY, m_HRESP,
        output s_HRDATA, s_HREADY, s_HRESP,
        output m_HADDR, m_HTRANS, m_HSIZE, m_HWRITE, m_HWDATA
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester strictly after ptr,
// wrapping around so ptr itself has the lowest priority.
module rr_arbiter #(
    parameter int unsigned HPORT_COUNT = 2,
    localparam int unsigned PtrW = $clog2(HPORT_COUNT)
) (
    input  logic [HPORT_COUNT-1:0] req,
    input  logic [PtrW-1:0]        ptr,
    output logic [HPORT_COUNT-1:0] gnt
);

    logic [HPORT_COUNT-1:0] gnt_hi;
    logic [HPORT_COUNT-1:0] gnt_lo;
    logic                   found_hi;
    logic                   found_lo;

    // Two passes: above the pointer first, then the whole vector as the wrap-around.
    always_comb begin
        gnt_hi   = '0;
        gnt_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = 0; i < int'(HPORT_COUNT); i++) begin
            if (!found_hi && req[i] && (i > int'(ptr))) begin
                gnt_hi[i] = 1'b1;
                found_hi  = 1'b1;
            end
            if (!found_lo && req[i]) begin
                gnt_lo[i] = 1'b1;
                found_lo  = 1'b1;
            end
        end
        gnt = found_hi ? gnt_hi : gnt_lo;
    end

endmodule

// File: rtl/ahb_lite_arbiter_nx1.sv
// AHB-Lite N:1 arbiter. Masters have no bus request line, so a losing address phase is
// captured into a per-port holding register and that master is stalled via its HREADY
// until the held request is issued downstream. Round-robin with burst lock.
module ahb_lite_arbiter_nx1
    import ahb_lite_pkg::*;
#(
    parameter int unsigned HDATA_WIDTH = 64,
    parameter int unsigned HADDR_WIDTH = 17,
    parameter int unsigned HPORT_COUNT = 2
) (
    input logic                 HCLK,
    input logic                 HRESETn,
    ahb_lite_arbiter_nx1_if.slave bus
);

    localparam int unsigned PtrW = $clog2(HPORT_COUNT);

    port_state_e                             state_q [HPORT_COUNT];
    logic [HPORT_COUNT-1:0][HADDR_WIDTH-1:0] hold_addr_q;
    logic [HPORT_COUNT-1:0][1:0]             hold_trans_q;
    logic [HPORT_COUNT-1:0][2:0]             hold_size_q;
    logic [HPORT_COUNT-1:0]                  hold_write_q;
    logic [PtrW-1:0]                         ptr_q;

    logic [HPORT_COUNT-1:0] hready;
    logic [HPORT_COUNT-1:0] live;
    logic [HPORT_COUNT-1:0] req;
    logic [HPORT_COUNT-1:0] rr_gnt;
    logic [HPORT_COUNT-1:0] win_oh;
    logic [PtrW-1:0]        win_idx;
    logic [PtrW-1:0]        owner_idx;
    logic [1:0]             m_trans;
    logic [HDATA_WIDTH-1:0] owner_wdata;
    logic                   lock;
    logic                   has_win;
    logic                   xfer;

    // Per-port ready, live request and request vector; locate the data owner.
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < int'(HPORT_COUNT); i++) begin
            case (state_q[i])
                DATA:    hready[i] = bus.m_HREADY;
                WAIT:    hready[i] = 1'b0;
                default: hready[i] = 1'b1;
            endcase
            live[i] = bus.s_HTRANS[i][1] & hready[i];
            req[i]  = (state_q[i] == WAIT) | live[i];
            if (state_q[i] == DATA) begin
                owner_idx = PtrW'(i);
            end
        end
    end

    // A burst continuation from the last granted port keeps the bus.
    assign lock = ((bus.s_HTRANS[ptr_q] == HTRANS_SEQ) || (bus.s_HTRANS[ptr_q] == HTRANS_BUSY))
                  && hready[ptr_q];

    rr_arbiter #(
        .HPORT_COUNT(HPORT_COUNT)
    ) u_rr (
        .req(req),
        .ptr(ptr_q),
        .gnt(rr_gnt)
    );

    // Final winner: locked port or round-robin pick, plus its index.
    always_comb begin
        win_idx = '0;
        has_win = lock | (|req);
        for (int i = 0; i < int'(HPORT_COUNT); i++) begin
            win_oh[i] = lock ? (ptr_q == PtrW'(i)) : rr_gnt[i];
            if (win_oh[i]) begin
                win_idx = PtrW'(i);
            end
        end
    end

    // Downstream address phase: held request (SEQ re-issued as NONSEQ) or live pass-through.
    always_comb begin
        if (state_q[win_idx] == WAIT) begin
            bus.m_HADDR  = hold_addr_q[win_idx];
            bus.m_HSIZE  = hold_size_q[win_idx];
            bus.m_HWRITE = hold_write_q[win_idx];
            m_trans      = (hold_trans_q[win_idx] == HTRANS_SEQ) ? HTRANS_NONSEQ
                                                                 : hold_trans_q[win_idx];
        end else begin
            bus.m_HADDR  = bus.s_HADDR[win_idx];
            bus.m_HSIZE  = bus.s_HSIZE[win_idx];
            bus.m_HWRITE = bus.s_HWRITE[win_idx];
            m_trans      = bus.s_HTRANS[win_idx];
        end
        if (!has_win) begin
            m_trans = HTRANS_IDLE;
        end
        bus.m_HTRANS = m_trans;
        xfer         = has_win & m_trans[1];
    end

    // Upstream responses and write-data steering follow the data owner.
    always_comb begin
        owner_wdata  = bus.s_HWDATA[owner_idx];
        bus.m_HWDATA = owner_wdata;
        for (int i = 0; i < int'(HPORT_COUNT); i++) begin
            bus.s_HREADY[i] = hready[i];
            bus.s_HRESP[i]  = (state_q[i] == DATA) & bus.m_HRESP;
            bus.s_HRDATA[i] = bus.m_HRDATA;
        end
    end

    // Port state machines, holding registers and pointer; everything freezes on a stall.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < int'(HPORT_COUNT); i++) begin
                state_q[i] <= IDLE;
            end
            hold_addr_q  <= '0;
            hold_trans_q <= '0;
            hold_size_q  <= '0;
            hold_write_q <= '0;
            ptr_q        <= PtrW'(HPORT_COUNT - 1);
        end else if (bus.m_HREADY) begin
            for (int i = 0; i < int'(HPORT_COUNT); i++) begin
                if (xfer && win_oh[i]) begin
                    state_q[i] <= DATA;
                end else if (live[i] && !win_oh[i]) begin
                    state_q[i]      <= WAIT;
                    hold_addr_q[i]  <= bus.s_HADDR[i];
                    hold_trans_q[i] <= bus.s_HTRANS[i];
                    hold_size_q[i]  <= bus.s_HSIZE[i];
                    hold_write_q[i] <= bus.s_HWRITE[i];
                end else if (state_q[i] == DATA) begin
                    state_q[i] <= IDLE;
                end
            end
            if (has_win) begin
                ptr_q <= win_idx;
            end
        end
    end

endmodule

// File: doc/ahb_lite_arbiter_nx1.md
# ahb_lite_arbiter_nx1

AHB-Lite N-master to 1-slave arbiter: shares one downstream AHB-Lite path (typically the input of the 1xN address-decoding interconnect) between several AHB-Lite masters such as CPU instruction and data ports. Masters lack HBUSREQ, so contended address phases are captured in per-port holding registers and the losing master is stalled through its own HREADY. Arbitration is round-robin, with a lock for in-progress bursts.

## Interface
- HDATA_WIDTH, 64, data bus width
- HADDR_WIDTH, 17, address width
- HPORT_COUNT, 2, number of masters, ≥2
- HCLK  in  1  clock
- HRESETn  in  1  reset; asynchronous, active-low (clock HCLK)
- s_HADDR  in  [HPORT_COUNT][HADDR_WIDTH]  per-master address
- s_HTRANS  in  [HPORT_COUNT][2]  per-master transfer type
- s_HSIZE  in  [HPORT_COUNT][3]  per-master size
- s_HWRITE  in  [HPORT_COUNT]  per-master write
- s_HWDATA  in  [HPORT_COUNT][HDATA_WIDTH]  per-master write data
- s_HRDATA  out  [HPORT_COUNT][HDATA_WIDTH]  read data, m_HRDATA broadcast
- s_HREADY  out  [HPORT_COUNT]  per-master ready
- s_HRESP  out  [HPORT_COUNT]  per-master response
- m_HADDR, m_HTRANS, m_HSIZE, m_HWRITE, m_HWDATA  out  same widths, single  downstream request
- m_HRDATA  in  HDATA_WIDTH  downstream read data
- m_HREADY  in  1  downstream ready, the downstream slave HREADY
- m_HRESP  in  1  downstream response

## Operation
- Per-port state: IDLE (nothing outstanding), WAIT (address phase captured, not yet issued), DATA (issued, in downstream data phase). At most one port is in DATA at a time; that port is the data owner.
- Live request of port i: s_HTRANS[i][1]=1 and s_HREADY[i]=1 in the same cycle.
- A port's request vector bit is set when the port is in WAIT, or when it has a live request.
- Grant is evaluated only when m_HREADY=1:
  - Burst lock: if the last granted port drives SEQ or BUSY live, that port keeps the grant.
  - Otherwise the winner is the first requester strictly after the last-granted pointer, wrapping round-robin.
  - The pointer updates to the winner.
- The downstream request (m_*) takes the winner's holding register if the winner is in WAIT, otherwise its live signals. When re-issued from WAIT, SEQ is converted to NONSEQ. With no winner, m_HTRANS=IDLE and the other m_* fields are don't-care.
- When m_HREADY=1 and the winner has a NONSEQ/SEQ transfer, the winner goes to DATA and becomes the data owner. The previous owner returns to IDLE unless it is also the winner.
- When m_HREADY=1 and there is no transfer, the previous data owner goes to IDLE.
- A live non-winning request is captured into that port's holding register (HADDR, HTRANS, HSIZE, HWRITE), and the port goes to WAIT.
- s_HREADY[i]:
  - data owner: m_HREADY
  - WAIT: 0
  - IDLE: 1
- s_HRESP[i]: m_HRESP if data owner, else 0. ERROR is passed through over both cycles.
- m_HWDATA = s_HWDATA[data owner].

## Timing
- Reset state:
  - all ports IDLE, no data owner, holding registers 0, pointer set so port 0 wins first.
  - Outputs: s_HREADY all 1, s_HRESP 0, m_HTRANS IDLE.
- Uncontended transfer: zero added latency; address path is combinational s_* → m_*.
- Each contended transfer gets ≥1 added wait state. A captured request is issued no earlier than the cycle after capture.
- If m_HREADY=0, the grant and all state hold, and no capture occurs.
- Simultaneous live requests: exactly one is issued and the others are captured the same cycle.
- Combinational paths: s_HTRANS/s_HADDR → m_*; m_HREADY/m_HRESP → s_HREADY/s_HRESP.
- A reset mid-transfer drops all WAIT and DATA state immediately.

## Structure
- Package ahb_lite_pkg holds:
  - HTRANS constants: HTRANS_IDLE=2'b00, HTRANS_BUSY=2'b01, HTRANS_NONSEQ=2'b10, HTRANS_SEQ=2'b11.
  - The port-state enum {IDLE, WAIT, DATA}.
- Sub-module rr_arbiter: request vector plus pointer in, one-hot grant out; purely combinational, parameterised by HPORT_COUNT.

## Test plan
- Single master, single read at 0x100 with zero wait states: m_HTRANS NONSEQ in the same cycle, s_HRDATA[0] valid next cycle, no stall.
- Ports 0 and 1 both issue NONSEQ after reset:
  - port 0 issued; port 1 captured, s_HREADY[1]=0.
  - port 1 issued next cycle as NONSEQ with its original address.
  - Both complete in order, and m_HWDATA follows the owner.
- Port 0 issues a 4-beat INCR burst (NONSEQ, SEQ×3) while port 1 requests at beat 2: port 1 is held in WAIT until the burst ends, then granted.
- Downstream inserts 2 wait states while port 1 is captured: no grant change, port 1 stays in WAIT, s_HREADY[0] low for exactly 2 cycles.
- Downstream ERROR response to port 1: s_HRESP[1]=1 for 2 cycles with s_HREADY[1]=0 then 1; s_HRESP[0] stays 0.
- HRESETn asserted while port 1 is in WAIT: s_HREADY all 1 and m_HTRANS IDLE immediately; the captured request is never issued.
